// File: rtl/status_ctrl.sv
// -----------------------------------------------------------------------------
// status_ctrl -- run/step/halt controller for a simple sequential processor.
//
// Tracks the processor execution state (IDLE, RUN, STEP, HALT, ERROR). It also
// keeps a registered copy of the last completed instruction's status and counts
// retired instructions and active cycles. Both counters saturate.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   stat_in      status of the completing instruction (1=AOK 2=ADR 3=INS 4=HLT)
//   instr_done   pulse: instruction completes this cycle, stat_in valid
//   start/step   pulses: free-run / single-step from IDLE
//   clear        pulse: back to IDLE from any state, counters zeroed
//   pc_en        combinational PC/regfile write enable
//   stat_q       registered processor status
//   halted/err   decoded from the HALT / ERROR states
//   instr_cnt    retired-instruction count (AOK and HLT retire)
//   cycle_cnt    cycles spent in RUN or STEP
// -----------------------------------------------------------------------------
module status_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       stat_in,
    input  logic             instr_done,
    input  logic             start,
    input  logic             step,
    input  logic             clear,
    output logic             pc_en,
    output logic [2:0]       stat_q,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] instr_cnt,
    output logic [CNT_W-1:0] cycle_cnt
);

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_ADR = 3'd2;
    localparam logic [2:0] STAT_INS = 3'd3;
    localparam logic [2:0] STAT_HLT = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_STEP  = 3'd2,
        S_HALT  = 3'd3,
        S_ERROR = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       stat_d;
    logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic             active;

    assign active = (state_q == S_RUN) || (state_q == S_STEP);

    always_comb begin
        state_d     = state_q;
        stat_d      = stat_q;
        instr_cnt_d = instr_cnt_q;
        cycle_cnt_d = cycle_cnt_q;

        if (clear) begin
            // clear beats start/step/instr_done sampled in the same cycle
            state_d     = S_IDLE;
            stat_d      = STAT_AOK;
            instr_cnt_d = '0;
            cycle_cnt_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start)     state_d = S_RUN;
                    else if (step) state_d = S_STEP;
                end
                S_RUN, S_STEP: begin
                    if (cycle_cnt_q != {CNT_W{1'b1}})
                        cycle_cnt_d = cycle_cnt_q + 1'b1;
                    if (instr_done) begin
                        case (stat_in)
                            STAT_AOK: begin
                                stat_d  = STAT_AOK;
                                state_d = (state_q == S_RUN) ? S_RUN : S_IDLE;
                            end
                            STAT_HLT: begin
                                stat_d  = STAT_HLT;
                                state_d = S_HALT;
                            end
                            STAT_ADR, STAT_INS: begin
                                stat_d  = stat_in;
                                state_d = S_ERROR;
                            end
                            // Unencoded status values are reported as INS.
                            default: begin
                                stat_d  = STAT_INS;
                                state_d = S_ERROR;
                            end
                        endcase
                        // HLT retires; faulting instructions do not.
                        if ((stat_in == STAT_AOK || stat_in == STAT_HLT) &&
                            instr_cnt_q != {CNT_W{1'b1}})
                            instr_cnt_d = instr_cnt_q + 1'b1;
                    end
                end
                default: ;  // HALT / ERROR sticky until clear or rst
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            stat_q      <= STAT_AOK;
            instr_cnt_q <= '0;
            cycle_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stat_q      <= stat_d;
            instr_cnt_q <= instr_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    // A halting or faulting instruction must never commit. The rst term makes
    // the abort independent of the state flop's async clear.
    assign pc_en     = active && !rst && !(instr_done && stat_in != STAT_AOK);
    assign halted    = (state_q == S_HALT);
    assign err       = (state_q == S_ERROR);
    assign instr_cnt = instr_cnt_q;
    assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_status_ctrl.sv
module tb_status_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] stat_in = 3'd0;
    logic       instr_done = 1'b0, start = 1'b0, step = 1'b0, clear = 1'b0;

    logic        pc_en, halted, err;
    logic [2:0]  stat_q;
    logic [31:0] instr_cnt, cycle_cnt;
    logic        pc_en4, halted4, err4;
    logic [2:0]  stat_q4;
    logic [3:0]  instr_cnt4, cycle_cnt4;

    int total = 0;
    int bad   = 0;

    status_ctrl dut (
        .clk(clk), .rst(rst), .stat_in(stat_in), .instr_done(instr_done),
        .start(start), .step(step), .clear(clear), .pc_en(pc_en),
        .stat_q(stat_q), .halted(halted), .err(err),
        .instr_cnt(instr_cnt), .cycle_cnt(cycle_cnt)
    );

    status_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .stat_in(stat_in), .instr_done(instr_done),
        .start(start), .step(step), .clear(clear), .pc_en(pc_en4),
        .stat_q(stat_q4), .halted(halted4), .err(err4),
        .instr_cnt(instr_cnt4), .cycle_cnt(cycle_cnt4)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_HALT = 3, M_ERR = 4;
    int    m_mode;
    int    m_stat;
    longint m_ic, m_cc;   // unbounded; saturation applied at compare time

    function automatic longint sat(longint v, int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst || clear) begin
            m_mode <= M_IDLE; m_stat <= 1; m_ic <= 0; m_cc <= 0;
        end else if (m_mode == M_IDLE) begin
            if (start)     m_mode <= M_RUN;
            else if (step) m_mode <= M_STEP;
        end else if (m_mode == M_RUN || m_mode == M_STEP) begin
            m_cc <= m_cc + 1;
            if (instr_done) begin
                if (stat_in == 3'd1 || stat_in == 3'd4) m_ic <= m_ic + 1;
                m_stat <= (stat_in >= 3'd1 && stat_in <= 3'd4) ? int'(stat_in) : 3;
                if (stat_in == 3'd1)      m_mode <= (m_mode == M_RUN) ? M_RUN : M_IDLE;
                else if (stat_in == 3'd4) m_mode <= M_HALT;
                else                      m_mode <= M_ERR;
            end
        end
    end

    function automatic bit exp_pc_en();
        return !rst && (m_mode == M_RUN || m_mode == M_STEP) &&
               !(instr_done && stat_in != 3'd1);
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, on the inactive edge.
    always @(negedge clk) begin
        check("m.pc_en",     pc_en,      exp_pc_en());
        check("m.stat_q",    stat_q,     m_stat);
        check("m.halted",    halted,     m_mode == M_HALT);
        check("m.err",       err,        m_mode == M_ERR);
        check("m.instr_cnt", instr_cnt,  sat(m_ic, 32));
        check("m.cycle_cnt", cycle_cnt,  sat(m_cc, 32));
        check("m.pc_en4",    pc_en4,     exp_pc_en());
        check("m.stat_q4",   stat_q4,    m_stat);
        check("m.instr4",    instr_cnt4, sat(m_ic, 4));
        check("m.cycle4",    cycle_cnt4, sat(m_cc, 4));
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic idle_in();
        start = 0; step = 0; clear = 0; instr_done = 0; stat_in = 3'd0;
    endtask

    task automatic pulse_clear();
        idle_in(); clear = 1; tick(); clear = 0;
    endtask

    initial begin
        idle_in();
        rst = 1; tick(); tick(); rst = 0; tick();
        check("rst.stat_q", stat_q, 1);
        check("rst.icnt", instr_cnt, 0);
        check("rst.ccnt", cycle_cnt, 0);
        check("rst.halted", halted, 0);
        check("rst.err", err, 0);
        check("rst.pc_en", pc_en, 0);
        tick();
        check("idle.stays", pc_en, 0);

        // start, 5 AOK, then HLT
        start = 1; tick(); start = 0;
        for (int i = 0; i < 5; i++) begin
            instr_done = 1; stat_in = 3'd1; tick();
        end
        stat_in = 3'd4; #1;
        check("hlt.pc_en", pc_en, 0);
        tick(); idle_in(); #1;
        check("hlt.halted", halted, 1);
        check("hlt.stat_q", stat_q, 4);
        check("hlt.icnt", instr_cnt, 6);
        check("hlt.ccnt", cycle_cnt, 6);
        check("hlt.pc_en_after", pc_en, 0);

        // clear+start in HALT -> IDLE
        clear = 1; start = 1; tick(); idle_in();
        check("clr.halted", halted, 0);
        check("clr.stat_q", stat_q, 1);
        check("clr.icnt", instr_cnt, 0);
        check("clr.ccnt", cycle_cnt, 0);
        check("clr.pc_en_idle", pc_en, 0);

        // ADR fault
        start = 1; tick(); start = 0;
        instr_done = 1; stat_in = 3'd2; #1;
        check("adr.pc_en", pc_en, 0);
        tick(); idle_in();
        check("adr.err", err, 1);
        check("adr.stat_q", stat_q, 2);
        check("adr.icnt", instr_cnt, 0);
        start = 1; tick(); start = 0;
        check("adr.sticky", err, 1);
        check("adr.sticky_pc", pc_en, 0);

        // illegal status -> INS
        pulse_clear();
        start = 1; tick(); start = 0;
        instr_done = 1; stat_in = 3'd6; tick(); idle_in();
        check("ill.err", err, 1);
        check("ill.stat_q", stat_q, 3);

        // single step with 3 waiting cycles
        pulse_clear();
        step = 1; tick(); step = 0;
        tick(); tick(); tick();
        instr_done = 1; stat_in = 3'd1; tick(); idle_in();
        check("step.icnt", instr_cnt, 1);
        check("step.ccnt", cycle_cnt, 4);
        check("step.idle_pc", pc_en, 0);
        step = 1; tick(); step = 0;
        instr_done = 1; stat_in = 3'd1; tick(); idle_in();
        check("step2.icnt", instr_cnt, 2);
        check("step2.ccnt", cycle_cnt, 5);

        // saturation of the narrow instance, then async reset mid-cycle
        pulse_clear();
        start = 1; tick(); start = 0;
        for (int i = 0; i < 20; i++) tick();
        check("sat.ccnt4", cycle_cnt4, 15);
        check("sat.ccnt32", cycle_cnt, 20);
        check("sat.pc_en", pc_en, 1);
        #2 rst = 1; #1;
        check("arst.pc_en", pc_en, 0);
        check("arst.ccnt4", cycle_cnt4, 0);
        check("arst.ccnt", cycle_cnt, 0);
        check("arst.stat_q", stat_q4, 1);
        tick(); rst = 0; tick();
        check("arst.idle", pc_en, 0);

        // randomized phase
        for (int c = 0; c < 4000; c++) begin
            start      = ($urandom_range(0, 7) == 0);
            step       = ($urandom_range(0, 7) == 0);
            clear      = ($urandom_range(0, 39) == 0);
            instr_done = $urandom_range(0, 1);
            stat_in    = ($urandom_range(0, 9) < 7) ? 3'd1 : 3'($urandom_range(0, 7));
            rst        = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 0; idle_in(); tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/status_ctrl.md
STATUS_CTRL -- requirements
Module: status_ctrl

Interface
REQ-001 Parameter CNT_W, default 32, width of the retired-instruction and cycle counters.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 stat_in  input  3  per-instruction status from the status stage: 1=AOK, 2=ADR (imem/dmem error), 3=INS (invalid instr), 4=HLT.
REQ-005 instr_done  input  1  one-cycle pulse; the current instruction completes this cycle and stat_in is valid.
REQ-006 start  input  1  pulse; begin free-running execution from IDLE.
REQ-007 step  input  1  pulse; execute exactly one instruction from IDLE.
REQ-008 clear  input  1  pulse; return from HALT/ERROR/any state to IDLE and zero counters.
REQ-009 pc_en  output  1  PC/register-file write enable for the processor this cycle.
REQ-010 stat_q  output  3  registered processor status (same encoding as stat_in).
REQ-011 halted  output  1  high in HALT state.
REQ-012 err  output  1  high in ERROR state.
REQ-013 instr_cnt  output  CNT_W  retired-instruction count.
REQ-014 cycle_cnt  output  CNT_W  cycles spent in RUN or STEP.

Function
REQ-015 FSM states IDLE, RUN, STEP, HALT, ERROR; state is registered, outputs halted/err are decoded from state.
REQ-016 IDLE: start -> RUN; step (without start) -> STEP; start and step together -> RUN.
REQ-017 RUN: instr_done with stat_in=1 -> stay RUN; stat_in=4 -> HALT; stat_in=2 or 3 -> ERROR; stat_in in {0,5,6,7} -> ERROR with stat_q=3.
REQ-018 STEP: instr_done with stat_in=1 -> IDLE; other stat_in values follow RUN rules (HALT/ERROR).
REQ-019 HALT and ERROR are sticky; only clear or rst leaves them; start/step/instr_done ignored there.
REQ-020 clear in any state -> IDLE next cycle, stat_q=1, both counters 0; clear has priority over start, step and instr_done in the same cycle.
REQ-021 stat_q updates on the clock edge in which instr_done is sampled in RUN/STEP; stat_in ignored when instr_done=0 or outside RUN/STEP.
REQ-022 pc_en combinational: 1 iff state is RUN or STEP and NOT (instr_done=1 and stat_in!=1); a faulting/halting instruction never updates PC.
REQ-023 pc_en=0 in IDLE, HALT, ERROR.
REQ-024 instr_cnt increments by 1 on instr_done in RUN/STEP when stat_in is 1 or 4 (HLT counts as retired); ADR/INS/illegal do not count.
REQ-025 cycle_cnt increments by 1 every cycle the state is RUN or STEP, including the completing cycle.
REQ-026 Both counters saturate at all-ones; no wrap to 0.
REQ-027 Latency: state/stat_q change visible one cycle after the sampling edge; no other pipeline delay.

Reset
REQ-028 rst asserted asynchronously forces state=IDLE, stat_q=1, instr_cnt=0, cycle_cnt=0; pc_en, halted, err read 0 while rst is high.
REQ-029 rst mid-RUN/STEP aborts the current instruction; pc_en drops immediately (combinationally) without waiting for a clock edge.
REQ-030 After rst deassertion, block stays in IDLE until start or step.

Verification
REQ-031 rst, start, 5 instr_done with stat_in=1, then instr_done with stat_in=4 -> HALT, halted=1, stat_q=4, instr_cnt=6, pc_en=0 in the halting cycle.
REQ-032 RUN, instr_done with stat_in=2 -> ERROR, err=1, stat_q=2, instr_cnt unchanged, pc_en=0 that cycle; later start ignored.
REQ-033 RUN, instr_done with stat_in=6 -> ERROR, stat_q=3.
REQ-034 IDLE, step, 3 idle cycles, then instr_done stat_in=1 -> IDLE, instr_cnt=1, cycle_cnt=4; a second step repeats and gives instr_cnt=2.
REQ-035 HALT, clear and start in the same cycle -> IDLE (not RUN), counters 0, stat_q=1.
REQ-036 CNT_W=4, RUN for 20 cycles -> cycle_cnt holds 15; rst asserted mid-cycle -> outputs reset before the next clock edge.
